// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared opcode, mux-select and width constants for the BIP processor
package bip_pkg;

    localparam int ADDR_W = 11;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/bip_program_counter.sv
// rtl/bip_program_counter.sv - 11-bit program counter, increments when wr_pc is set
module bip_program_counter
    import bip_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_pc,
    output logic [ADDR_W-1:0] pc
);

    // Natural 11-bit overflow gives the 2047 -> 0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (wr_pc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/control_block.sv
// rtl/control_block.sv - BIP instruction decoder and program counter
module control_block
    import bip_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  OpCode,
    output logic [1:0]        SelA,
    output logic              SelB,
    output logic              WrAcc,
    output logic              Op,
    output logic              WrRam,
    output logic              RdRam,
    output logic [ADDR_W-1:0] Addr
);

    logic wrPc;

    assign wrPc = (OpCode != OP_HLT);

    // Controls are held inactive while reset is asserted so the datapath cannot write.
    always_comb begin
        SelA  = SELA_RAM;
        SelB  = SELB_RAM;
        WrAcc = 1'b0;
        Op    = ALU_ADD;
        WrRam = 1'b0;
        RdRam = 1'b0;
        if (rst_n) begin
            case (OpCode)
                OP_STO: begin
                    WrRam = 1'b1;
                end
                OP_LD: begin
                    SelA  = SELA_RAM;
                    WrAcc = 1'b1;
                    RdRam = 1'b1;
                end
                OP_LDI: begin
                    SelA  = SELA_IMM;
                    WrAcc = 1'b1;
                end
                OP_ADD: begin
                    SelA  = SELA_ALU;
                    SelB  = SELB_RAM;
                    Op    = ALU_ADD;
                    WrAcc = 1'b1;
                    RdRam = 1'b1;
                end
                OP_ADDI: begin
                    SelA  = SELA_ALU;
                    SelB  = SELB_IMM;
                    Op    = ALU_ADD;
                    WrAcc = 1'b1;
                end
                OP_SUB: begin
                    SelA  = SELA_ALU;
                    SelB  = SELB_RAM;
                    Op    = ALU_SUB;
                    WrAcc = 1'b1;
                    RdRam = 1'b1;
                end
                OP_SUBI: begin
                    SelA  = SELA_ALU;
                    SelB  = SELB_IMM;
                    Op    = ALU_SUB;
                    WrAcc = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    bip_program_counter u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_pc (wrPc),
        .pc    (Addr)
    );

endmodule

// File: tb/tb_control_block.sv
// tb/tb_control_block.sv - self-checking bench for control_block
module tb_control_block;

    typedef struct {
        logic [4:0] opc;
        logic [6:0] ctl;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  OpCode;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic        Op;
    logic        WrRam;
    logic        RdRam;
    logic [10:0] Addr;

    int          nChecks;
    int          nFail;
    int          modelPc;
    vec_t        vecs[10];
    logic [6:0]  refCtl[8];

    control_block dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .OpCode (OpCode),
        .SelA   (SelA),
        .SelB   (SelB),
        .WrAcc  (WrAcc),
        .Op     (Op),
        .WrRam  (WrRam),
        .RdRam  (RdRam),
        .Addr   (Addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] expCtl(input logic [4:0] opc);
        if (opc < 5'd8) return refCtl[opc[2:0]];
        return 7'b0;
    endfunction

    task automatic checkCtl(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {SelA, SelB, WrAcc, Op, WrRam, RdRam};
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s ctl {SelA,SelB,WrAcc,Op,WrRam,RdRam}: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkAddr(input string name, input int exp);
        nChecks++;
        if (Addr !== 11'(exp)) begin
            nFail++;
            $display("FAIL %s Addr: got %0d expected %0d", name, Addr, exp);
        end
    endtask

    // Called shortly after a falling edge; asserts reset asynchronously, then releases before the next rise.
    task automatic doReset(input string name);
        rst_n = 1'b0;
        #1;
        checkAddr({name, "_rst"}, 0);
        checkCtl({name, "_rst"}, 7'b0);
        #1;
        rst_n   = 1'b1;
        modelPc = 0;
    endtask

    // Applies one opcode for one clock, checking decode before the edge and PC after it.
    task automatic cycle(input string name, input logic [4:0] opc, input logic [6:0] exp);
        OpCode = opc;
        #1;
        checkCtl(name, exp);
        checkAddr({name, "_pre"}, modelPc);
        @(posedge clk);
        if (opc != 5'b00000) modelPc = (modelPc + 1) % 2048;
        #1;
        checkAddr({name, "_post"}, modelPc);
        @(negedge clk);
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        modelPc = 0;
        rst_n   = 1'b0;
        OpCode  = 5'b00001;

        vecs[0] = '{5'b00000, 7'b00_0_0_0_0_0};
        vecs[1] = '{5'b00001, 7'b00_0_0_0_1_0};
        vecs[2] = '{5'b00010, 7'b00_0_1_0_0_1};
        vecs[3] = '{5'b00011, 7'b01_0_1_0_0_0};
        vecs[4] = '{5'b00100, 7'b10_0_1_0_0_1};
        vecs[5] = '{5'b00101, 7'b10_1_1_0_0_0};
        vecs[6] = '{5'b00110, 7'b10_0_1_1_0_1};
        vecs[7] = '{5'b00111, 7'b10_1_1_1_0_0};
        vecs[8] = '{5'b01000, 7'b00_0_0_0_0_0};
        vecs[9] = '{5'b11111, 7'b00_0_0_0_0_0};
        for (int i = 0; i < 8; i++) refCtl[vecs[i].opc[2:0]] = vecs[i].ctl;

        doReset("init");

        // Halted processor must stay on address 0, then STO walks the PC to 10.
        for (int i = 0; i < 10; i++) cycle("hlt", 5'b00000, 7'b0);
        checkAddr("hlt_hold", 0);
        for (int i = 0; i < 10; i++) cycle("sto", 5'b00001, 7'b00_0_0_0_1_0);
        checkAddr("sto_ten", 10);

        // Mid-count reset with STO still applied: PC and strobes must drop immediately.
        doReset("midrst");
        cycle("after_rst", 5'b00001, 7'b00_0_0_0_1_0);
        checkAddr("after_rst_one", 1);

        for (int v = 0; v < 10; v++) begin
            doReset($sformatf("vec%0d", v));
            for (int c = 0; c < 10; c++) cycle($sformatf("vec%0d", v), vecs[v].opc, vecs[v].ctl);
            checkAddr($sformatf("vec%0d_end", v), (vecs[v].opc == 5'b00000) ? 0 : 10);
        end

        doReset("rand");
        for (int i = 0; i < 300; i++) begin
            logic [4:0] r;
            r = 5'($urandom_range(0, 31));
            if (r == 5'b00000 && $urandom_range(0, 3) != 0) r = 5'($urandom_range(1, 7));
            cycle("rand", r, expCtl(r));
        end

        doReset("wrap");
        for (int i = 0; i < 2047; i++) cycle("wrap", 5'b00001, expCtl(5'b00001));
        checkAddr("wrap_top", 2047);
        cycle("wrap_last", 5'b11111, 7'b0);
        checkAddr("wrap_zero", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
